// File: rtl/bip_host_link_pkg.sv
// Shared constants for the host link and the CPU-side interface:
// FSM state encodings and default parameter values.
package bip_host_link_pkg;

  localparam int BHL_NBIT_DATA_LEN_DEF  = 8;
  localparam int BHL_LEN_DATA_DEF       = 16;
  localparam int BHL_TIMEOUT_CYCLES_DEF = 1000000;

  localparam int BHL_STATE_W = 3;

  localparam logic [BHL_STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [BHL_STATE_W-1:0] ST_SEND_CMD  = 3'd1;
  localparam logic [BHL_STATE_W-1:0] ST_WAIT_ACC1 = 3'd2;
  localparam logic [BHL_STATE_W-1:0] ST_WAIT_ACC2 = 3'd3;
  localparam logic [BHL_STATE_W-1:0] ST_WAIT_CLK  = 3'd4;
  localparam logic [BHL_STATE_W-1:0] ST_DONE      = 3'd5;

endpackage

// File: rtl/tick_edge.sv
// Rising-edge detector for level-held UART done ticks. The delay register
// resets to 1 so a tick already high at reset release is not seen as an edge.
module tick_edge (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  output logic edge_o
);

  logic tick_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tick_q <= 1'b1;
    else        tick_q <= tick_i;
  end

  assign edge_o = tick_i & ~tick_q;

endmodule

// File: rtl/bip_host_link.sv
// Host-side command/response link: sends one command byte over the UART,
// then collects the accumulator (two bytes) and the CPU cycle count.
//
// state        | meaning
// IDLE         | waiting for go
// SEND_CMD     | tx_start high until the UART TX reports done
// WAIT_ACC1    | waiting for accumulator low byte
// WAIT_ACC2    | waiting for accumulator high byte
// WAIT_CLK     | waiting for cycle-count byte
// DONE         | one-cycle result_valid, then back to IDLE
module bip_host_link
  import bip_host_link_pkg::*;
#(
  parameter int NBIT_DATA_LEN  = BHL_NBIT_DATA_LEN_DEF,
  parameter int len_data       = BHL_LEN_DATA_DEF,
  parameter int TIMEOUT_CYCLES = BHL_TIMEOUT_CYCLES_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     go,
  input  logic [NBIT_DATA_LEN-1:0] cmd_in,
  input  logic                     tx_done_tick,
  input  logic                     rx_done_tick,
  input  logic [NBIT_DATA_LEN-1:0] rx_data_in,
  output logic                     tx_start,
  output logic [NBIT_DATA_LEN-1:0] tx_data,
  output logic [len_data-1:0]      acc_out,
  output logic [NBIT_DATA_LEN-1:0] clk_count_out,
  output logic                     result_valid,
  output logic                     busy,
  output logic                     timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [BHL_STATE_W-1:0]   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [NBIT_DATA_LEN-1:0] tx_data_q, tx_data_d;
  logic [len_data-1:0]      acc_q, acc_d;
  logic [NBIT_DATA_LEN-1:0] clk_cnt_q, clk_cnt_d;
  logic                     tx_start_q;
  logic                     result_valid_q;
  logic                     busy_q;
  logic                     timeout_q, timeout_d;
  logic                     tx_edge;
  logic                     rx_edge;

  tick_edge u_tx_edge (
    .clk    (clk),
    .reset  (reset),
    .tick_i (tx_done_tick),
    .edge_o (tx_edge)
  );

  tick_edge u_rx_edge (
    .clk    (clk),
    .reset  (reset),
    .tick_i (rx_done_tick),
    .edge_o (rx_edge)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    acc_d     = acc_q;
    clk_cnt_d = clk_cnt_q;
    timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          tx_data_d = cmd_in;
          state_d   = ST_SEND_CMD;
        end
      end

      ST_SEND_CMD: begin
        if (tx_edge) begin
          cnt_d   = '0;
          state_d = ST_WAIT_ACC1;
        end
      end

      ST_WAIT_ACC1, ST_WAIT_ACC2, ST_WAIT_CLK: begin
        // An arriving byte wins over terminal count on the same cycle.
        if (rx_edge) begin
          cnt_d = '0;
          case (state_q)
            ST_WAIT_ACC1: begin
              acc_d[NBIT_DATA_LEN-1:0] = rx_data_in;
              state_d                  = ST_WAIT_ACC2;
            end
            ST_WAIT_ACC2: begin
              acc_d[2*NBIT_DATA_LEN-1:NBIT_DATA_LEN] = rx_data_in;
              state_d                                = ST_WAIT_CLK;
            end
            default: begin
              clk_cnt_d = rx_data_in;
              state_d   = ST_DONE;
            end
          endcase
        end else if (cnt_q == CNT_TC) begin
          cnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      tx_data_q      <= '0;
      acc_q          <= '0;
      clk_cnt_q      <= '0;
      tx_start_q     <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tx_data_q      <= tx_data_d;
      acc_q          <= acc_d;
      clk_cnt_q      <= clk_cnt_d;
      // Status flags follow the next state so they line up with state_q.
      tx_start_q     <= (state_d == ST_SEND_CMD);
      result_valid_q <= (state_d == ST_DONE);
      busy_q         <= (state_d != ST_IDLE);
      timeout_q      <= timeout_d;
    end
  end

  assign tx_start      = tx_start_q;
  assign tx_data       = tx_data_q;
  assign acc_out       = acc_q;
  assign clk_count_out = clk_cnt_q;
  assign result_valid  = result_valid_q;
  assign busy          = busy_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_bip_host_link.sv
// Directed bench for bip_host_link with a short timeout (16 cycles).
module tb_bip_host_link;

  logic        clk;
  logic        reset;
  logic        go;
  logic [7:0]  cmd_in;
  logic        tx_done_tick;
  logic        rx_done_tick;
  logic [7:0]  rx_data_in;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [15:0] acc_out;
  logic [7:0]  clk_count_out;
  logic        result_valid;
  logic        busy;
  logic        timeout;

  int tests_run    = 0;
  int tests_failed = 0;
  int rv_cnt       = 0;
  int to_cnt       = 0;

  bip_host_link #(
    .NBIT_DATA_LEN  (8),
    .len_data       (16),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .go            (go),
    .cmd_in        (cmd_in),
    .tx_done_tick  (tx_done_tick),
    .rx_done_tick  (rx_done_tick),
    .rx_data_in    (rx_data_in),
    .tx_start      (tx_start),
    .tx_data       (tx_data),
    .acc_out       (acc_out),
    .clk_count_out (clk_count_out),
    .result_valid  (result_valid),
    .busy          (busy),
    .timeout       (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters: each registers one count per cycle the output was high.
  always @(posedge clk) begin
    if (result_valid) rv_cnt <= rv_cnt + 1;
    if (timeout)      to_cnt <= to_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data_in   = b;
    rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
    step();
  endtask

  task automatic start_txn(input logic [7:0] c);
    cmd_in = c;
    go     = 1'b1;
    step();
    go           = 1'b0;
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    go = 1'b0; cmd_in = 8'h00; tx_done_tick = 1'b0;
    rx_done_tick = 1'b0; rx_data_in = 8'h00;
    #1;
    tests_run++;
    if ({tx_start, tx_data, acc_out, clk_count_out, result_valid, busy, timeout} !== 36'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected 0",
               {tx_start, tx_data, acc_out, clk_count_out, result_valid, busy, timeout});
    end
    step(); step();
    reset = 1'b1;
    step();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_basic();
    int rv0;
    rv0 = rv_cnt;
    cmd_in = 8'h01;
    go     = 1'b1;
    step();
    go = 1'b0;
    tests_run++;
    if ({tx_start, busy, tx_data} !== {1'b1, 1'b1, 8'h01}) begin
      tests_failed++;
      $display("FAIL basic_send_cmd: got tx_start/busy/tx_data=%b/%b/%h expected 1/1/01",
               tx_start, busy, tx_data);
    end
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    tests_run++;
    if (tx_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_tx_start_drop: got %b expected 0", tx_start);
    end
    send_byte(8'h34);
    send_byte(8'h12);
    rx_data_in   = 8'h07;
    rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
    tests_run++;
    if (result_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_result_valid: got %b expected 1", result_valid);
    end
    step();
    step();
    tests_run++;
    if ({acc_out, clk_count_out, busy} !== {16'h1234, 8'h07, 1'b0}) begin
      tests_failed++;
      $display("FAIL basic_result: got acc=%h clk=%h busy=%b expected 1234/07/0",
               acc_out, clk_count_out, busy);
    end
    tests_run++;
    if (rv_cnt - rv0 !== 1) begin
      tests_failed++;
      $display("FAIL basic_rv_pulses: got %0d expected 1", rv_cnt - rv0);
    end
  endtask

  task automatic test_discard();
    send_byte(8'hFF);
    tests_run++;
    if ({acc_out, busy} !== {16'h1234, 1'b0}) begin
      tests_failed++;
      $display("FAIL discard_idle: got acc=%h busy=%b expected 1234/0", acc_out, busy);
    end
    cmd_in = 8'h5A;
    go     = 1'b1;
    step();
    go = 1'b0;
    send_byte(8'hEE);
    tests_run++;
    if ({tx_start, acc_out} !== {1'b1, 16'h1234}) begin
      tests_failed++;
      $display("FAIL discard_send_cmd: got tx_start=%b acc=%h expected 1/1234", tx_start, acc_out);
    end
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'hEF);
    tests_run++;
    if ({acc_out, clk_count_out, tx_data} !== {16'hCDAB, 8'hEF, 8'h5A}) begin
      tests_failed++;
      $display("FAIL discard_result: got acc=%h clk=%h tx_data=%h expected CDAB/EF/5A",
               acc_out, clk_count_out, tx_data);
    end
  endtask

  task automatic test_go_ignored();
    start_txn(8'hA5);
    send_byte(8'h11);
    cmd_in = 8'h3C;
    go     = 1'b1;
    step();
    step();
    go = 1'b0;
    tests_run++;
    if ({tx_data, tx_start, busy} !== {8'hA5, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL go_ignored: got tx_data=%h tx_start=%b busy=%b expected A5/0/1",
               tx_data, tx_start, busy);
    end
    send_byte(8'h22);
    send_byte(8'h33);
    tests_run++;
    if ({acc_out, clk_count_out, busy} !== {16'h2211, 8'h33, 1'b0}) begin
      tests_failed++;
      $display("FAIL go_ignored_result: got acc=%h clk=%h busy=%b expected 2211/33/0",
               acc_out, clk_count_out, busy);
    end
  endtask

  task automatic test_held_tick();
    int rv0, to0;
    rv0 = rv_cnt;
    to0 = to_cnt;
    start_txn(8'h01);
    rx_data_in   = 8'hAA;
    rx_done_tick = 1'b1;
    step();
    rx_data_in = 8'hBB;
    for (int i = 1; i < 20; i++) step();
    rx_done_tick = 1'b0;
    step();
    tests_run++;
    if ({acc_out, clk_count_out} !== {16'h22AA, 8'h33}) begin
      tests_failed++;
      $display("FAIL held_tick_capture: got acc=%h clk=%h expected 22AA/33", acc_out, clk_count_out);
    end
    tests_run++;
    if ({rv_cnt - rv0, to_cnt - to0} !== {32'd0, 32'd1}) begin
      tests_failed++;
      $display("FAIL held_tick_pulses: got rv=%0d to=%0d expected 0/1", rv_cnt - rv0, to_cnt - to0);
    end
  endtask

  task automatic test_timeout();
    int found, rv0;
    found = -1;
    rv0   = rv_cnt;
    start_txn(8'h02);
    rx_data_in   = 8'h56;
    rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (timeout === 1'b1) begin
        found = k;
        break;
      end
    end
    tests_run++;
    if (found != 16) begin
      tests_failed++;
      $display("FAIL timeout_latency: got %0d expected 16", found);
    end
    tests_run++;
    if ({busy, acc_out} !== {1'b0, 16'h2256}) begin
      tests_failed++;
      $display("FAIL timeout_state: got busy=%b acc=%h expected 0/2256", busy, acc_out);
    end
    step();
    tests_run++;
    if ({timeout, result_valid} !== 2'b00 || rv_cnt != rv0) begin
      tests_failed++;
      $display("FAIL timeout_pulse_end: got timeout=%b rv_pulses=%0d expected 0/0",
               timeout, rv_cnt - rv0);
    end
  endtask

  task automatic test_tc_edge();
    int to0, rv0;
    to0 = to_cnt;
    rv0 = rv_cnt;
    start_txn(8'h03);
    rx_data_in   = 8'h77;
    rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
    for (int i = 0; i < 15; i++) step();
    rx_data_in   = 8'h88;
    rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
    tests_run++;
    if ({acc_out, timeout, busy} !== {16'h8877, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL tc_edge_accept: got acc=%h timeout=%b busy=%b expected 8877/0/1",
               acc_out, timeout, busy);
    end
    step();
    send_byte(8'h99);
    tests_run++;
    if ({clk_count_out, busy} !== {8'h99, 1'b0} || to_cnt != to0 || rv_cnt - rv0 != 1) begin
      tests_failed++;
      $display("FAIL tc_edge_finish: got clk=%h busy=%b to=%0d rv=%0d expected 99/0/0/1",
               clk_count_out, busy, to_cnt - to0, rv_cnt - rv0);
    end
  endtask

  task automatic test_reset_mid();
    int to0, rv0;
    start_txn(8'h04);
    send_byte(8'h44);
    send_byte(8'h55);
    to0 = to_cnt;
    rv0 = rv_cnt;
    rx_data_in   = 8'h66;
    rx_done_tick = 1'b1;
    reset        = 1'b0;
    #1;
    tests_run++;
    if ({tx_start, tx_data, acc_out, clk_count_out, result_valid, busy, timeout} !== 36'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_async: got %h expected 0",
               {tx_start, tx_data, acc_out, clk_count_out, result_valid, busy, timeout});
    end
    step(); step();
    reset = 1'b1;
    step(); step(); step();
    tests_run++;
    if ({acc_out, clk_count_out, busy, tx_data} !== 33'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_release: got acc=%h clk=%h busy=%b tx_data=%h expected 0",
               acc_out, clk_count_out, busy, tx_data);
    end
    tests_run++;
    if (to_cnt != to0 || rv_cnt != rv0) begin
      tests_failed++;
      $display("FAIL reset_mid_pulses: got to=%0d rv=%0d expected 0/0", to_cnt - to0, rv_cnt - rv0);
    end
    rx_done_tick = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_discard();
    test_go_ignored();
    test_held_tick();
    test_timeout();
    test_tc_edge();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bip_host_link.md
BIP_HOST_LINK -- requirements
Module: bip_host_link

Interface
REQ-001 The block SHALL have parameter NBIT_DATA_LEN, default 8, meaning the UART byte width.
REQ-002 The block SHALL have parameter len_data, default 16, meaning the accumulator width, assembled from two bytes.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning the maximum idle clock cycles allowed between expected response bytes.
REQ-004 Ports, in order:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- go  input  1  request to issue one command/response transaction.
- cmd_in  input  NBIT_DATA_LEN  command byte sent to the CPU side (bit0 = cpu_start).
- tx_done_tick  input  1  UART TX completion; level-held, so only its rising edge counts.
- rx_done_tick  input  1  UART RX byte available; level-held, so only its rising edge counts.
- rx_data_in  input  NBIT_DATA_LEN  received UART byte.
- tx_start  output  1  request to the UART TX to transmit tx_data.
- tx_data  output  NBIT_DATA_LEN  byte for the UART TX.
- acc_out  output  len_data  assembled accumulator result.
- clk_count_out  output  NBIT_DATA_LEN  received CPU cycle count.
- result_valid  output  1  one-cycle pulse when a complete result is captured.
- busy  output  1  high whenever the state is not IDLE.
- timeout  output  1  one-cycle pulse when a transaction is aborted.

Function
REQ-005 The FSM SHALL have six states: IDLE, SEND_CMD, WAIT_ACC1, WAIT_ACC2, WAIT_CLK, DONE.
REQ-006 An edge SHALL be a cycle in which the tick input is 1 and its one-cycle-delayed register is 0.
REQ-007 In IDLE, go=1 SHALL latch cmd_in into tx_data and move the FSM to SEND_CMD; tx_start SHALL be 1 from the next cycle.
REQ-008 go SHALL be ignored in every state other than IDLE.
REQ-009 tx_start SHALL be 1 only in SEND_CMD, and a tx_done edge SHALL move the FSM to WAIT_ACC1.
REQ-010 In WAIT_ACC1, an rx_done edge SHALL capture rx_data_in into acc_out[7:0] and move the FSM to WAIT_ACC2.
REQ-011 In WAIT_ACC2, an rx_done edge SHALL capture rx_data_in into acc_out[15:8] and move the FSM to WAIT_CLK.
REQ-012 In WAIT_CLK, an rx_done edge SHALL capture rx_data_in into clk_count_out and move the FSM to DONE.
REQ-013 In DONE, result_valid SHALL be 1 for exactly that one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-014 rx_done edges in IDLE, SEND_CMD or DONE SHALL be discarded.
REQ-015 acc_out and clk_count_out SHALL hold their values until overwritten by a later capture.
REQ-016 An unsigned timeout counter SHALL clear on entry to WAIT_ACC1 and on every accepted byte, and SHALL increment each cycle spent in a WAIT_* state.
REQ-017 When the counter equals TIMEOUT_CYCLES-1 in a WAIT_* state with no rx_done edge, timeout SHALL pulse for one cycle and the FSM SHALL go to IDLE; result_valid SHALL NOT assert.
REQ-018 If an rx_done edge coincides with the counter reaching terminal count, the byte SHALL be accepted and timeout SHALL NOT assert.
REQ-019 SEND_CMD SHALL have no timeout.
REQ-020 All outputs SHALL be driven from registers.

Reset
REQ-021 On reset=0, the block SHALL immediately set the state to IDLE.
REQ-022 On reset=0, tx_start, tx_data, acc_out, clk_count_out, result_valid, busy, timeout and the counter SHALL all be 0.
REQ-023 Both tick-delay registers SHALL reset to 1, so that a tick held high at reset release produces no edge.
REQ-024 Asserting reset mid-transaction SHALL abort the transaction with no result_valid or timeout pulse.

Structure
REQ-025 The state encodings and the default parameter values SHALL live in a shared include file that is also used by the CPU-side interface.
REQ-026 Rising-edge detection SHALL be one sub-module, tick_edge, instantiated twice (once for tx_done_tick, once for rx_done_tick).

Verification
REQ-027 go with cmd_in=8'h01, then a tx_done edge, then bytes 8'h34, 8'h12, 8'h07 -> acc_out=16'h1234, clk_count_out=8'h07, one result_valid pulse, busy low afterwards.
REQ-028 rx_done_tick held high for 20 cycles in WAIT_ACC1 -> exactly one byte captured.
REQ-029 TIMEOUT_CYCLES=16 with no response after ACC1 -> timeout pulse 16 cycles after the ACC1 capture, FSM in IDLE, acc_out[7:0] kept, no result_valid.
REQ-030 go pulsed during WAIT_ACC2 -> ignored, tx_data unchanged, tx_start stays 0.
REQ-031 reset pulsed low in WAIT_CLK with rx_done_tick=1 at release -> all outputs 0, FSM in IDLE, no spurious capture.
REQ-032 rx_done edge on the exact cycle the counter reaches TIMEOUT_CYCLES-1 -> byte accepted, no timeout pulse.
